sdram_wrdata_feed: RTL and testbench

//  Write-data feeder directly upstream of the SDRAM data-bus driver. Buffers

---
 rtl/sdram_pkg.sv | 32 +++
 rtl/sdram_wrdata_feed_sync_fifo.sv | 54 +++++
 rtl/sdram_wrdata_feed.sv | 135 +++++++++++++
 tb/tb_sdram_wrdata_feed.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM controller state encodings and write-feed FSM states
`timescale 1ns/1ps
package sdram_pkg;

  typedef enum logic [3:0] {
    W_IDLE   = 4'd0,
    W_PRE    = 4'd1,
    W_AR     = 4'd2,
    W_MRS    = 4'd3,
    W_ACTIVE = 4'd4,
    W_TRCD   = 4'd5,
    W_READ   = 4'd6,
    W_CL     = 4'd7,
    W_RD     = 4'd8,
    W_WRITE  = 4'd9,
    W_WD     = 4'd10,
    W_TWR    = 4'd11,
    W_TRP    = 4'd12,
    W_TRFC   = 4'd13,
    W_TRPACT = 4'd14
  } work_state_e;

  // work_st arrives on a 5-bit bus
  localparam logic [4:0] W_WRITE_ST = {1'b0, W_WRITE};

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_REQ   = 2'd1,
    F_BURST = 2'd2
  } feed_state_e;

endpackage

// File: rtl/sdram_wrdata_feed_sync_fifo.sv
// rtl/sdram_wrdata_feed_sync_fifo.sv - single-clock FIFO (sync_fifo) with occupancy count
`timescale 1ns/1ps
module sync_fifo #(
  parameter int DW = 16,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  // count never exceeds DEPTH, so its top bit alone means full
  assign full  = count[AW];
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_wrdata_feed.sv
// rtl/sdram_wrdata_feed.sv - buffers pixel words and feeds SDRAM write bursts
// Optional frame_start flush input enabled by WRFEED_FRAME_FLUSH_EN.
`timescale 1ns/1ps
module sdram_wrdata_feed
  import sdram_pkg::*;
#(
  parameter int DW        = 16,
  parameter int AW        = 9,
  parameter int BURST_LEN = 256
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef WRFEED_FRAME_FLUSH_EN
  input  logic          frame_start,
`endif
  input  logic          pix_vld,
  input  logic [DW-1:0] pix_data,
  input  logic [4:0]    work_st,
  input  logic [15:0]   cnt_work,
  output logic [DW-1:0] wr_sdram_data,
  output logic          wr_req,
  output logic          burst_done,
  output logic [AW:0]   fifo_cnt,
  output logic          ovf_err,
  output logic          udf_err
);

  localparam int          BW     = $clog2(BURST_LEN + 1);
  localparam logic [AW:0] THRESH = (AW+1)'(BURST_LEN);
  localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

  feed_state_e   state;
  logic [BW-1:0] beat;
  logic          flush;
  logic          in_write;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [DW-1:0] head;
  logic          unused_cnt_work;

`ifdef WRFEED_FRAME_FLUSH_EN
  assign flush = frame_start;
`else
  assign flush = 1'b0;
`endif

  assign unused_cnt_work = ^cnt_work;

  assign in_write = (work_st == W_WRITE_ST);
  assign pop      = in_write & ~empty & ~flush;
  // a pop in the same cycle frees the slot, so a push at full is still accepted
  assign push     = pix_vld & (~full | pop) & ~flush;

  sync_fifo #(.DW(DW), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .din   (pix_data),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= F_IDLE;
      beat          <= '0;
      wr_req        <= 1'b0;
      burst_done    <= 1'b0;
      wr_sdram_data <= '0;
      ovf_err       <= 1'b0;
      udf_err       <= 1'b0;
    end else if (flush) begin
      state      <= F_IDLE;
      beat       <= '0;
      wr_req     <= 1'b0;
      burst_done <= 1'b0;
      ovf_err    <= 1'b0;
      udf_err    <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      if (pop) begin
        wr_sdram_data <= head;
      end else if (in_write) begin
        wr_sdram_data <= '0;
        udf_err       <= 1'b1;
      end
      if (pix_vld && !push) ovf_err <= 1'b1;

      case (state)
        F_IDLE: begin
          if (fifo_cnt >= THRESH) begin
            state  <= F_REQ;
            wr_req <= 1'b1;
          end
        end
        F_REQ: begin
          // the first W_WRITE cycle is already beat 0 of the burst
          if (in_write) begin
            wr_req <= 1'b0;
            if (BURST_LEN == 1) begin
              burst_done <= 1'b1;
              state      <= F_IDLE;
            end else begin
              beat  <= BW'(1);
              state <= F_BURST;
            end
          end
        end
        F_BURST: begin
          if (!in_write) begin
            beat  <= '0;
            state <= F_IDLE;
          end else if (beat == LAST) begin
            burst_done <= 1'b1;
            beat       <= '0;
            state      <= F_IDLE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        default: begin
          beat  <= '0;
          state <= F_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wrdata_feed.sv
// tb/tb_sdram_wrdata_feed.sv - self-checking bench for sdram_wrdata_feed against a queue model
`timescale 1ns/1ps
module tb_sdram_wrdata_feed;
  import sdram_pkg::*;

  localparam int         BURST = 256;
  localparam int         DEPTH = 512;
  localparam logic [4:0] WR    = {1'b0, W_WRITE};
  localparam logic [4:0] IDL   = {1'b0, W_IDLE};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_vld = 1'b0;
  logic [15:0] pix_data = '0;
  logic [4:0]  work_st = '0;
  logic [15:0] cnt_work = '0;
`ifdef WRFEED_FRAME_FLUSH_EN
  logic        frame_start = 1'b0;
`endif
  logic [15:0] wr_sdram_data;
  logic        wr_req;
  logic        burst_done;
  logic [9:0]  fifo_cnt;
  logic        ovf_err;
  logic        udf_err;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [15:0] mq[$];
  logic [15:0] m_data;
  logic        m_ovf, m_udf, m_req, m_done, m_burst;
  int          m_beats;

  always #5 clk = ~clk;

  sdram_wrdata_feed dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef WRFEED_FRAME_FLUSH_EN
    .frame_start   (frame_start),
`endif
    .pix_vld       (pix_vld),
    .pix_data      (pix_data),
    .work_st       (work_st),
    .cnt_work      (cnt_work),
    .wr_sdram_data (wr_sdram_data),
    .wr_req        (wr_req),
    .burst_done    (burst_done),
    .fifo_cnt      (fifo_cnt),
    .ovf_err       (ovf_err),
    .udf_err       (udf_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_data  = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_req   = 1'b0;
    m_done  = 1'b0;
    m_burst = 1'b0;
    m_beats = 0;
  endtask

  // one clock edge of the reference behaviour, using pre-edge occupancy
  task automatic model_edge(input logic vld, input logic [15:0] d, input logic [4:0] st, input logic fs);
    int held;
    bit wr, do_pop, do_push;
    held = mq.size();
    wr   = (st == WR);
    m_done = 1'b0;
    if (fs) begin
      mq.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_req = 1'b0; m_burst = 1'b0; m_beats = 0;
      return;
    end
    do_pop  = wr && (held > 0);
    do_push = vld && ((held < DEPTH) || do_pop);
    if (vld && !do_push) m_ovf = 1'b1;
    if (wr && held == 0) begin m_udf = 1'b1; m_data = '0; end
    if (do_pop) m_data = mq.pop_front();
    if (do_push) mq.push_back(d);
    if (m_burst) begin
      if (!wr) begin m_burst = 1'b0; m_beats = 0; end
      else if (m_beats == BURST - 1) begin m_done = 1'b1; m_burst = 1'b0; m_beats = 0; end
      else m_beats++;
    end else if (m_req) begin
      if (wr) begin m_req = 1'b0; m_burst = 1'b1; m_beats = 1; end
    end else if (held >= BURST) begin
      m_req = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"},  32'(wr_sdram_data), 32'(m_data));
    check({tag, ".req"},   32'(wr_req),        32'(m_req));
    check({tag, ".done"},  32'(burst_done),    32'(m_done));
    check({tag, ".cnt"},   32'(fifo_cnt),      32'(mq.size()));
    check({tag, ".ovf"},   32'(ovf_err),       32'(m_ovf));
    check({tag, ".udf"},   32'(udf_err),       32'(m_udf));
  endtask

  task automatic step(input string tag, input logic vld, input logic [15:0] d, input logic [4:0] st, input logic fs);
    pix_vld  = vld;
    pix_data = d;
    work_st  = st;
    cnt_work = 16'($urandom);
`ifdef WRFEED_FRAME_FLUSH_EN
    frame_start = fs;
`endif
    @(posedge clk);
    model_edge(vld, d, st, fs);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    int pulses;
    model_reset();
    #12;
    check("reset.data", 32'(wr_sdram_data), 32'd0);
    check("reset.req",  32'(wr_req),        32'd0);
    check("reset.done", 32'(burst_done),    32'd0);
    check("reset.cnt",  32'(fifo_cnt),      32'd0);
    check("reset.ovf",  32'(ovf_err),       32'd0);
    check("reset.udf",  32'(udf_err),       32'd0);
    rst_n = 1'b1;

    // fill one burst, request follows the count by one cycle
    for (int i = 0; i < BURST; i++) step("fill", 1'b1, 16'(i), IDL, 1'b0);
    check("t1.cnt256", 32'(fifo_cnt), 32'd256);
    check("t1.req_lag", 32'(wr_req), 32'd0);
    for (int i = 0; i < 4; i++) step("t1.hold", 1'b0, 16'h0, IDL, 1'b0);
    check("t1.req", 32'(wr_req), 32'd1);

    // full burst drain
    pulses = 0;
    for (int i = 0; i < BURST; i++) begin
      step("burst", 1'b0, 16'h0, WR, 1'b0);
      check("t2.seq", 32'(wr_sdram_data), 32'(i));
      if (burst_done) pulses++;
    end
    step("t2.after", 1'b0, 16'h0, IDL, 1'b0);
    if (burst_done) pulses++;
    check("t2.pulses", 32'(pulses), 32'd1);
    check("t2.cnt", 32'(fifo_cnt), 32'd0);
    check("t2.req", 32'(wr_req), 32'd0);

    // overflow
    for (int i = 0; i < DEPTH + 1; i++) step("ovf", 1'b1, 16'($urandom), IDL, 1'b0);
    check("t3.cnt512", 32'(fifo_cnt), 32'd512);
    check("t3.ovf", 32'(ovf_err), 32'd1);
    for (int i = 0; i < 3; i++) step("t3.sticky", 1'b0, 16'h0, IDL, 1'b0);
    check("t3.ovf_sticky", 32'(ovf_err), 32'd1);

    // drain past empty, then push+pop on empty
    for (int i = 0; i < DEPTH + 1; i++) step("drain", 1'b0, 16'h0, WR, 1'b0);
    check("t4.udf", 32'(udf_err), 32'd1);
    check("t4.data0", 32'(wr_sdram_data), 32'd0);
    step("t4.pp", 1'b1, 16'hABCD, WR, 1'b0);
    check("t4.pp_data", 32'(wr_sdram_data), 32'd0);
    check("t4.pp_cnt", 32'(fifo_cnt), 32'd1);
    step("t4.pop", 1'b0, 16'h0, WR, 1'b0);
    check("t4.bypass", 32'(wr_sdram_data), 32'hABCD);

    // push+pop at full must not flag overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) step("fill512", 1'b1, 16'($urandom), IDL, 1'b0);
    step("t3b.pp", 1'b1, 16'h1234, WR, 1'b0);
    check("t3b.ovf", 32'(ovf_err), 32'd0);
    check("t3b.cnt", 32'(fifo_cnt), 32'd512);

    // randomized traffic with alternating write pressure
    for (int i = 0; i < 1600; i++) begin
      logic [4:0] st;
      int pw;
      pw = ((i / 200) % 2 == 1) ? 95 : 20;
      st = ($urandom_range(0, 99) < pw) ? WR : 5'($urandom_range(0, 8));
      step("rand", ($urandom_range(0, 9) < 6), 16'($urandom), st, 1'b0);
    end

    // asynchronous reset mid-burst
    do_reset();
    for (int i = 0; i < BURST; i++) step("t5.fill", 1'b1, 16'($urandom), IDL, 1'b0);
    step("t5.req", 1'b0, 16'h0, IDL, 1'b0);
    for (int i = 0; i < 100; i++) step("t5.burst", 1'b0, 16'h0, WR, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5.data", 32'(wr_sdram_data), 32'd0);
    check("t5.req",  32'(wr_req),        32'd0);
    check("t5.done", 32'(burst_done),    32'd0);
    check("t5.cnt",  32'(fifo_cnt),      32'd0);
    check("t5.ovf",  32'(ovf_err),       32'd0);
    check("t5.udf",  32'(udf_err),       32'd0);
    @(posedge clk);
    #2;
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("t5.post", 1'b0, 16'h0, IDL, 1'b0);
    check("t5.post_cnt", 32'(fifo_cnt), 32'd0);
    check("t5.post_req", 32'(wr_req), 32'd0);

`ifdef WRFEED_FRAME_FLUSH_EN
    for (int i = 0; i < DEPTH + 8; i++) step("t6.fill", 1'b1, 16'($urandom), IDL, 1'b0);
    check("t6.ovf_pre", 32'(ovf_err), 32'd1);
    step("t6.flush", 1'b1, 16'h5555, IDL, 1'b1);
    check("t6.cnt", 32'(fifo_cnt), 32'd0);
    check("t6.ovf", 32'(ovf_err), 32'd0);
    check("t6.udf", 32'(udf_err), 32'd0);
    check("t6.req", 32'(wr_req), 32'd0);
    for (int i = 0; i < 20; i++) step("t6.after", 1'b1, 16'($urandom), IDL, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
